minterm_func_gen: RTL and testbench
===================================

Name: minterm_func_gen

Overview:
- Parametrised, pipelined sum-of-minterms function generator.
- An N_IN-to-2^N_IN line decoder drives N_FUNC independent OR-planes, each selected by a runtime-programmable minterm mask.
- Masks are loaded serially through a cfg handshake into shadow registers and committed atomically.
- Sits in the combinational-lab datapath as the reusable successor to fixed decoder-based boolean functions.

Parameters:
- N_IN, 3, number of input variables; the decoder has 2^N_IN outputs.
- N_FUNC, 2, number of independent output functions (channels).
- M, 2^N_IN (derived localparam, not overridable), mask width per function.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input variables valid this cycle.
- in_vars  input  N_IN  variable vector; MSB is the first variable (x), LSB the last (z).
- out_valid  output  1  out_f valid.
- out_f  output  N_FUNC  function results; bit k is function k.
- cfg_start  input  1  begin mask load; sampled only in IDLE.
- cfg_sel  input  clog2(N_FUNC) (min 1)  target function; captured on cfg_start.
- cfg_bit_valid  input  1  serial mask bit present.
- cfg_bit  input  1  mask bit, MSB first (minterm M-1 first, minterm 0 last).
- cfg_busy  output  1  high while in LOAD or COMMIT.
- cfg_done  output  1  one-cycle pulse when the new mask is live.

Behaviour:
- Reset (rst_n low at a clk edge): all masks clear to 0, shadow register clears to 0, bit counter 0, state IDLE, out_valid 0, out_f 0, cfg_busy 0, cfg_done 0.
  - Mid-load reset discards the partial load; previously committed masks are also cleared.
- Evaluation pipeline, fixed latency 2; accepts one input per cycle, no backpressure.
  - Stage 1: register in_valid and the one-hot decode D = 1 << in_vars.
  - Stage 2: out_f[k] = OR over i of (D[i] AND mask[k][i]); out_valid = stage-1 valid.
  - When stage-1 valid is 0, out_f holds its last value.
- Mask used for a result is the mask live at the cycle stage 2 registers. Mask changes take effect exactly on the cycle after cfg_done.
- Config FSM states:
  - IDLE: cfg_busy 0. On cfg_start, latch cfg_sel and clear the counter -> LOAD.
  - LOAD: on each cfg_bit_valid, shadow = {shadow[M-2:0], cfg_bit} and counter++. When the M-th bit is accepted -> COMMIT. Cycles with cfg_bit_valid low stall with no timeout.
  - COMMIT: mask[sel] <= shadow; cfg_done = 1 for this cycle -> IDLE.
- cfg_start in LOAD or COMMIT is ignored. cfg_start is accepted in the same cycle the FSM returns to IDLE (the cycle after COMMIT).
- cfg_sel >= N_FUNC: the load completes and cfg_done pulses, but no mask is written.
- Evaluation continues uninterrupted during a load. Channels other than sel are never disturbed. Channel sel uses its old mask until the commit.
- Counter width is clog2(M)+1; no wrap inside LOAD.
- Equal-valued masks on two channels give identical outputs; mask all-ones gives constant 1; mask 0 gives constant 0.

Decomposition:
- Shared package minterm_pkg holds:
  - cfg state enum {IDLE, LOAD, COMMIT};
  - function clog2_min1 for the select width;
  - constant CFG_MSB_FIRST = 1, documenting bit order.
- One sub-module: decoder_n_to_2n (parameter N). Registered one-hot decoder with valid, synchronous active-low reset, latency 1. It generalises the team's 3x8 decoder and is reused by other lab blocks.

Test Plan:
- Reset then inputs 0..7 -> out_valid is 1 two cycles after each in_valid; out_f = 2'b00 for all inputs.
- Load func 0 with 8'hAA, i.e. Sum(1,3,5,7) -> cfg_done pulses 10 cycles after cfg_start (8 bits plus COMMIT, with bits back-to-back). Then inputs 0..7 give out_f[0] = z = 0,1,0,1,0,1,0,1 and out_f[1] = 0.
- Load func 1 with 8'h96 (odd parity) while streaming inputs every cycle:
  - results registered before the commit show out_f[1] = 0;
  - results from the cycle after cfg_done match parity of 0..7: 0,1,1,0,1,0,0,1;
  - out_f[0] keeps the 8'hAA pattern throughout.
- Load with 3-cycle gaps between cfg_bit_valid pulses, plus cfg_start pulses inside LOAD -> mask is still correct, and exactly one cfg_done pulse is seen.
- Assert rst_n low after 4 of 8 bits on func 0 (holding 8'hAA) -> cfg_busy 0 and out_f 0 next cycle. A fresh load of 8'hFF then gives out_f[0] = 1 for every input.
- N_IN=4, N_FUNC=3, load func 2 = 16'h8000 -> out_f[2] = 1 only for in_vars = 4'hF; cfg_sel = 3 completes with cfg_done and leaves all masks unchanged.

Source files
------------

// File: rtl/minterm_pkg.sv
// rtl/minterm_pkg.sv - shared types and helpers for the minterm function generator
package minterm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  // Serial mask bits arrive minterm M-1 first, minterm 0 last.
  localparam bit CFG_MSB_FIRST = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/decoder_n_to_2n.sv
// rtl/decoder_n_to_2n.sv - registered N-to-2^N one-hot decoder with valid, latency 1
module decoder_n_to_2n #(
  parameter int N = 3,
  localparam int W = 1 << N
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  input  logic [N-1:0] sel_i,
  output logic         valid_o,
  output logic [W-1:0] onehot_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] onehot_q, onehot_d;

  always_comb begin
    valid_d  = valid_i;
    onehot_d = onehot_q;
    if (valid_i) begin
      onehot_d        = '0;
      onehot_d[sel_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      onehot_q <= '0;
    end else begin
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
    end
  end

  assign valid_o  = valid_q;
  assign onehot_o = onehot_q;

endmodule

// File: rtl/minterm_func_gen.sv
// rtl/minterm_func_gen.sv - pipelined sum-of-minterms generator with serially loaded masks
module minterm_func_gen
  import minterm_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_FUNC = 2,
  localparam int M     = 1 << N_IN,
  localparam int SEL_W = clog2_min1(N_FUNC),
  localparam int CNT_W = $clog2(M) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [N_IN-1:0]   in_vars,
  output logic              out_valid,
  output logic [N_FUNC-1:0] out_f,
  input  logic              cfg_start,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic              cfg_bit_valid,
  input  logic              cfg_bit,
  output logic              cfg_busy,
  output logic              cfg_done
);

  cfg_state_e state_q, state_d;

  logic [SEL_W-1:0]           sel_q, sel_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [M-1:0]               shadow_q, shadow_d;
  logic [N_FUNC-1:0][M-1:0]   mask_q, mask_d;
  logic                       out_valid_q, out_valid_d;
  logic [N_FUNC-1:0]          out_f_q, out_f_d;

  logic         start_acc;
  logic         shift_en;
  logic         commit_en;
  logic         dec_valid;
  logic [M-1:0] dec_onehot;

  // Stage 1: registered one-hot decode of the input variables.
  decoder_n_to_2n #(
    .N (N_IN)
  ) u_decoder (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .valid_i  (in_valid),
    .sel_i    (in_vars),
    .valid_o  (dec_valid),
    .onehot_o (dec_onehot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_start) state_d = LOAD;
      LOAD:    if (cfg_bit_valid && (cnt_q == CNT_W'(M - 1))) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_busy  = 1'b0;
    cfg_done  = 1'b0;
    start_acc = 1'b0;
    shift_en  = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      IDLE: start_acc = cfg_start;
      LOAD: begin
        cfg_busy = 1'b1;
        shift_en = cfg_bit_valid;
      end
      COMMIT: begin
        cfg_busy  = 1'b1;
        cfg_done  = 1'b1;
        commit_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (start_acc) begin
      sel_d = cfg_sel;
      cnt_d = '0;
    end
    if (shift_en) begin
      cnt_d    = cnt_q + 1'b1;
      shadow_d = CFG_MSB_FIRST ? {shadow_q[M-2:0], cfg_bit} : {cfg_bit, shadow_q[M-1:1]};
    end
  end

  // An out-of-range select matches no channel, so the commit writes nothing.
  always_comb begin
    mask_d = mask_q;
    for (int k = 0; k < N_FUNC; k++) begin
      if (commit_en && (sel_q == SEL_W'(k))) begin
        mask_d[k] = shadow_q;
      end
    end
  end

  // Stage 2: OR-plane per channel against the mask live at this edge.
  always_comb begin
    out_valid_d = dec_valid;
    out_f_d     = out_f_q;
    if (dec_valid) begin
      for (int k = 0; k < N_FUNC; k++) begin
        out_f_d[k] = |(dec_onehot & mask_q[k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
    end else begin
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_f_q     <= out_f_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_f     = out_f_q;

endmodule

// File: tb/tb_minterm_func_gen.sv
// tb/tb_minterm_func_gen.sv - scoreboard bench for minterm_func_gen (3x2 and 4x3 instances)
module tb_minterm_func_gen;

  typedef struct {
    int vars;
    int cyc;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_in_valid, a_out_valid, a_cfg_start, a_cfg_bit_valid, a_cfg_bit, a_cfg_busy, a_cfg_done;
  logic [2:0] a_in_vars;
  logic [1:0] a_out_f;
  logic [0:0] a_cfg_sel;

  logic       b_in_valid, b_out_valid, b_cfg_start, b_cfg_bit_valid, b_cfg_bit, b_cfg_busy, b_cfg_done;
  logic [3:0] b_in_vars;
  logic [2:0] b_out_f;
  logic [1:0] b_cfg_sel;

  minterm_func_gen #(.N_IN(3), .N_FUNC(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_vars(a_in_vars),
    .out_valid(a_out_valid), .out_f(a_out_f), .cfg_start(a_cfg_start), .cfg_sel(a_cfg_sel),
    .cfg_bit_valid(a_cfg_bit_valid), .cfg_bit(a_cfg_bit), .cfg_busy(a_cfg_busy), .cfg_done(a_cfg_done)
  );

  minterm_func_gen #(.N_IN(4), .N_FUNC(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_vars(b_in_vars),
    .out_valid(b_out_valid), .out_f(b_out_f), .cfg_start(b_cfg_start), .cfg_sel(b_cfg_sel),
    .cfg_bit_valid(b_cfg_bit_valid), .cfg_bit(b_cfg_bit), .cfg_busy(b_cfg_busy), .cfg_done(b_cfg_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] mask_a [2];
  logic [15:0] mask_b [3];
  ent_t        qa[$];
  ent_t        qb[$];
  logic [1:0]  a_last;
  logic [2:0]  b_last;
  bit          mon_en = 1'b0;
  int          a_done_cnt = 0, b_done_cnt = 0, a_done_cyc = 0, b_done_cyc = 0;

  always @(negedge clk) begin
    if (a_cfg_done) begin a_done_cnt++; a_done_cyc = cyc; end
    if (b_cfg_done) begin b_done_cnt++; b_done_cyc = cyc; end
  end

  always @(negedge clk) begin
    ent_t       e;
    logic [1:0] ea;
    logic [2:0] eb;
    if (mon_en) begin
      if (a_out_valid) begin
        if (qa.size() == 0) check("a_spurious_valid", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_latency", cyc - e.cyc, 2);
          for (int k = 0; k < 2; k++) ea[k] = mask_a[k][e.vars];
          check("a_out_f", a_out_f, ea);
          a_last = ea;
        end
      end else check("a_hold", a_out_f, a_last);
      if (b_out_valid) begin
        if (qb.size() == 0) check("b_spurious_valid", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_latency", cyc - e.cyc, 2);
          for (int k = 0; k < 3; k++) eb[k] = mask_b[k][e.vars];
          check("b_out_f", b_out_f, eb);
          b_last = eb;
        end
      end else check("b_hold", b_out_f, b_last);
    end
  end

  task automatic clear_model();
    for (int k = 0; k < 2; k++) mask_a[k] = '0;
    for (int k = 0; k < 3; k++) mask_b[k] = '0;
    qa.delete();
    qb.delete();
    a_last = '0;
    b_last = '0;
  endtask

  task automatic set_cfg(input int which, input logic st, input int sel, input logic bv, input logic bt);
    if (which == 0) begin
      a_cfg_start = st; a_cfg_sel = sel[0]; a_cfg_bit_valid = bv; a_cfg_bit = bt;
    end else begin
      b_cfg_start = st; b_cfg_sel = sel[1:0]; b_cfg_bit_valid = bv; b_cfg_bit = bt;
    end
  endtask

  // Called just after a rising edge with the config FSM idle.
  task automatic load(input int which, input int sel, input logic [15:0] val,
                      input int gap, input bit poke, input int abort_at);
    int m, nf, s, d0, dc;
    m  = (which == 0) ? 8 : 16;
    nf = (which == 0) ? 2 : 3;
    d0 = (which == 0) ? a_done_cnt : b_done_cnt;
    s  = cyc;
    set_cfg(which, 1'b1, sel, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("busy_in_load", (which == 0) ? a_cfg_busy : b_cfg_busy, 1);
    for (int j = 0; j < m; j++) begin
      if (j == abort_at) begin
        mon_en = 1'b0;
        rst_n  = 1'b0;
        set_cfg(which, 1'b0, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
        check("abort_busy", a_cfg_busy, 0);
        check("abort_out_f", a_out_f, 0);
        mon_en = 1'b1;
        return;
      end
      set_cfg(which, 1'b0, sel, 1'b1, val[m-1-j]);
      @(posedge clk); #1;
      for (int g = 0; g < gap && j < m - 1; g++) begin
        set_cfg(which, poke, sel ^ 1, 1'b0, ~val[m-1-j]);
        @(posedge clk); #1;
      end
    end
    set_cfg(which, 1'b0, sel, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk); #1;
    if (which == 0 && sel < nf) mask_a[sel] = val;
    if (which == 1 && sel < nf) mask_b[sel] = val;
    dc = (which == 0) ? a_done_cyc : b_done_cyc;
    check("done_count", ((which == 0) ? a_done_cnt : b_done_cnt) - d0, 1);
    check("done_latency", dc - s + 1, (m - 1) * (gap + 1) + 3);
    @(posedge clk); #1;
    check("busy_after", (which == 0) ? a_cfg_busy : b_cfg_busy, 0);
  endtask

  task automatic stream(input int which, input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc = cyc;
      if (which == 0) begin
        e.vars = i % 8;
        a_in_valid = 1'b1; a_in_vars = 3'(e.vars);
        qa.push_back(e);
      end else begin
        e.vars = i % 16;
        b_in_valid = 1'b1; b_in_vars = 4'(e.vars);
        qb.push_back(e);
      end
      @(posedge clk); #1;
    end
    if (which == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_vars = '0; b_in_valid = 1'b0; b_in_vars = '0;
    set_cfg(0, 1'b0, 0, 1'b0, 1'b0);
    set_cfg(1, 1'b0, 0, 1'b0, 1'b0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_f", a_out_f, 0);
    check("rst_a_busy", a_cfg_busy, 0);
    check("rst_a_done", a_cfg_done, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_out_f", b_out_f, 0);
    check("rst_b_busy", b_cfg_busy, 0);
    mon_en = 1'b1;

    stream(0, 8);
    drain();

    load(0, 0, 16'h00AA, 0, 1'b0, -1);
    stream(0, 8);
    drain();

    fork
      stream(0, 32);
      load(0, 1, 16'h0096, 0, 1'b0, -1);
    join
    drain();

    load(0, 1, 16'h003C, 3, 1'b1, -1);
    stream(0, 8);
    drain();

    load(0, 0, 16'h00FF, 0, 1'b0, 4);
    load(0, 0, 16'h00FF, 0, 1'b0, -1);
    stream(0, 8);
    drain();

    load(1, 2, 16'h8000, 0, 1'b0, -1);
    stream(1, 16);
    drain();
    load(1, 3, 16'hFFFF, 0, 1'b0, -1);
    stream(1, 16);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
